// File: rtl/median_feeder_pkg.sv
// Shared types and helpers for the median filter column feeder.
// The frame row-length check is enabled by defining FEEDER_FRAME_CHECK_EN.
package median_feeder_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int IMG_W_DEF = 64;
  localparam int IMG_H_DEF = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Index of the line buffer holding a given row (row mod 3).
  typedef logic [1:0] slot_t;

  // Number of 4-row passes in a frame of img_h rows (odd rows 3..img_h-1).
  function automatic int num_passes(input int img_h);
    return (img_h - 2) / 2;
  endfunction

  // Advance a line-buffer slot index modulo 3.
  function automatic slot_t slot_inc(input slot_t s);
    slot_t r;
    case (s)
      2'd0:    r = 2'd1;
      2'd1:    r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/median_line_buf.sv
// One line of pixel-pair storage: single-port synchronous RAM that returns
// the old contents of the addressed word when the same address is written.
module median_line_buf #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array write; no reset so it maps onto block or distributed RAM.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Read port register: captures the word before this cycle's write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= {WIDTH{1'b0}};
    end else if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/median_column_feeder.sv
// Front end of the parallel median filter: buffers three lines of a
// two-pixel-per-beat raster and emits 4-row x 2-column slices while odd rows
// from row 3 onward stream in. Optional row-length checking is compiled in
// when FEEDER_FRAME_CHECK_EN is defined; otherwise s_eol is ignored.
module median_column_feeder
  import median_feeder_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [2*PIX_W-1:0] s_data,
  input  logic               s_sof,
  input  logic               s_eol,
  output logic               m_valid,
  output logic [4*PIX_W-1:0] m_c0,
  output logic [4*PIX_W-1:0] m_c1,
  output logic               m_sol,
  output logic               m_eol,
  output logic               m_eof,
  output logic               frame_err
);

  localparam int HALF_W = IMG_W / 2;
  localparam int CW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int RW     = $clog2(IMG_H);
  localparam int DW     = 2 * PIX_W;

  localparam logic [CW-1:0] COL_LAST      = CW'(HALF_W - 1);
  // Last emitting row: row 3 plus two rows per further pass, i.e. IMG_H-1.
  localparam logic [RW-1:0] ROW_LAST      = RW'(2 * num_passes(IMG_H) + 1);
  localparam logic [RW-1:0] ROW_FILL_LAST = RW'(2);

  state_t          state_r, state_next_s, eff_state_s;
  logic [CW-1:0]   col_r, col_next_s, eff_col_s;
  logic [RW-1:0]   row_r, row_next_s, eff_row_s;
  slot_t           slot_r, slot_next_s, eff_slot_s;

  logic            acc_s, restart_s, active_s, emit_s, last_col_s, row_end_s;

  logic [DW-1:0]   rdata_s [3];
  logic [DW-1:0]   old_s, mid_s, new_s;
  logic [DW-1:0]   beat_r;
  slot_t           sel_r;

  logic            m_valid_r, m_sol_r, m_eol_r, m_eof_r;

  // Input is always accepted outside reset; there is no backpressure source.
  assign s_ready = ~rst;

  // Decode the current beat: an accepted s_sof overrides position to row 0, col 0.
  always_comb begin
    acc_s     = s_valid && s_ready;
    restart_s = acc_s && s_sof;
    if (restart_s) begin
      eff_state_s = FILL;
      eff_col_s   = {CW{1'b0}};
      eff_row_s   = {RW{1'b0}};
      eff_slot_s  = 2'd0;
    end else begin
      eff_state_s = state_r;
      eff_col_s   = col_r;
      eff_row_s   = row_r;
      eff_slot_s  = slot_r;
    end
    active_s   = acc_s && (eff_state_s != IDLE);
    last_col_s = (eff_col_s == COL_LAST);
`ifdef FEEDER_FRAME_CHECK_EN
    row_end_s  = last_col_s || s_eol;
`else
    row_end_s  = last_col_s;
`endif
    emit_s     = active_s && (eff_state_s == STREAM) && eff_row_s[0];
  end

  // Next-state and position counters; everything holds on cycles without a stored beat.
  always_comb begin
    state_next_s = state_r;
    col_next_s   = col_r;
    row_next_s   = row_r;
    slot_next_s  = slot_r;
    if (active_s) begin
      if (row_end_s) begin
        col_next_s  = {CW{1'b0}};
        row_next_s  = eff_row_s + RW'(1);
        slot_next_s = slot_inc(eff_slot_s);
        case (eff_state_s)
          FILL:    state_next_s = (eff_row_s == ROW_FILL_LAST) ? STREAM : FILL;
          STREAM:  state_next_s = (eff_row_s == ROW_LAST) ? IDLE : STREAM;
          default: state_next_s = IDLE;
        endcase
      end else begin
        col_next_s   = eff_col_s + CW'(1);
        row_next_s   = eff_row_s;
        slot_next_s  = eff_slot_s;
        state_next_s = eff_state_s;
      end
    end else begin
      state_next_s = state_r;
    end
  end

  // FSM state and position registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      col_r   <= {CW{1'b0}};
      row_r   <= {RW{1'b0}};
      slot_r  <= 2'd0;
    end else begin
      state_r <= state_next_s;
      col_r   <= col_next_s;
      row_r   <= row_next_s;
      slot_r  <= slot_next_s;
    end
  end

  // Three line buffers; the incoming row overwrites the row three lines older.
  for (genvar k = 0; k < 3; k++) begin : g_buf
    median_line_buf #(
      .DEPTH(HALF_W),
      .WIDTH(DW)
    ) u_buf (
      .clk  (clk),
      .rst  (rst),
      .en   (active_s),
      .we   (active_s && (eff_slot_s == slot_t'(k))),
      .addr (eff_col_s),
      .wdata(s_data),
      .rdata(rdata_s[k])
    );
  end

  // Slice flags and the newest-row beat, aligned with the buffer read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_r <= 1'b0;
      m_sol_r   <= 1'b0;
      m_eol_r   <= 1'b0;
      m_eof_r   <= 1'b0;
      beat_r    <= {DW{1'b0}};
      sel_r     <= 2'd0;
    end else begin
      m_valid_r <= emit_s;
      m_sol_r   <= emit_s && (eff_col_s == {CW{1'b0}});
      m_eol_r   <= emit_s && last_col_s;
      m_eof_r   <= emit_s && last_col_s && (eff_row_s == ROW_LAST);
      if (emit_s) begin
        beat_r <= s_data;
        sel_r  <= eff_slot_s;
      end
    end
  end

  // Order buffered rows oldest-first: the slot being overwritten holds row r-3.
  always_comb begin
    case (sel_r)
      2'd0: begin
        old_s = rdata_s[0];
        mid_s = rdata_s[1];
        new_s = rdata_s[2];
      end
      2'd1: begin
        old_s = rdata_s[1];
        mid_s = rdata_s[2];
        new_s = rdata_s[0];
      end
      2'd2: begin
        old_s = rdata_s[2];
        mid_s = rdata_s[0];
        new_s = rdata_s[1];
      end
      default: begin
        old_s = rdata_s[0];
        mid_s = rdata_s[1];
        new_s = rdata_s[2];
      end
    endcase
  end

  assign m_valid = m_valid_r;
  assign m_sol   = m_sol_r;
  assign m_eol   = m_eol_r;
  assign m_eof   = m_eof_r;
  assign m_c0    = {beat_r[PIX_W-1:0], new_s[PIX_W-1:0],
                    mid_s[PIX_W-1:0],  old_s[PIX_W-1:0]};
  assign m_c1    = {beat_r[DW-1:PIX_W], new_s[DW-1:PIX_W],
                    mid_s[DW-1:PIX_W],  old_s[DW-1:PIX_W]};

`ifdef FEEDER_FRAME_CHECK_EN
  logic frame_err_r;

  // Sticky row-length error: s_eol must coincide with the last column of a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_r <= 1'b0;
    end else if (active_s) begin
      frame_err_r <= (frame_err_r && !restart_s) || (s_eol != last_col_s);
    end
  end

  assign frame_err = frame_err_r;
`else
  logic unused_eol;
  assign unused_eol = s_eol;
  assign frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_median_column_feeder.sv
// Self-checking bench for median_column_feeder on an 8x8 frame: random and
// patterned pixels, gaps, restarts and mid-frame reset, checked against a
// frame-image reference model.
module tb_median_column_feeder;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int HW = W / 2;
  localparam int NB = H * HW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = 16'h0000;
  logic        s_sof = 1'b0;
  logic        s_eol = 1'b0;
  logic        m_valid;
  logic [31:0] m_c0;
  logic [31:0] m_c1;
  logic        m_sol;
  logic        m_eol;
  logic        m_eof;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int dut_slices = 0;
  int eof_at = 0;

  // Reference model: the frame as an image plus the beat index within it.
  bit          act = 1'b0;
  int          k = 0;
  logic [7:0]  img [H][W];
  logic        exp_err;

  median_column_feeder #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_sof(s_sof), .s_eol(s_eol), .m_valid(m_valid),
    .m_c0(m_c0), .m_c1(m_c1), .m_sol(m_sol), .m_eol(m_eol), .m_eof(m_eof),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle, update the model, then check the registered output.
  task automatic beat(input bit v, input bit sof, input bit eol, input logic [15:0] d);
    int r;
    int c;
    bit ev;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [2:0]  ef;
    ev = 1'b0;
    e0 = 32'h0;
    e1 = 32'h0;
    ef = 3'b000;
    s_valid = v;
    s_sof   = sof;
    s_eol   = eol;
    s_data  = d;
    if (v) begin
      if (sof) begin
        act = 1'b1;
        k = 0;
      end
      if (act) begin
        r = k / HW;
        c = k % HW;
        img[r][2*c]   = d[7:0];
        img[r][2*c+1] = d[15:8];
        if (r >= 3 && (r % 2) == 1) begin
          ev = 1'b1;
          e0 = {img[r][2*c],   img[r-1][2*c],   img[r-2][2*c],   img[r-3][2*c]};
          e1 = {img[r][2*c+1], img[r-1][2*c+1], img[r-2][2*c+1], img[r-3][2*c+1]};
          ef = {c == 0, c == HW-1, (c == HW-1) && (r == H-1)};
        end
        k++;
        if (k == NB) act = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (m_valid === 1'b1) begin
      dut_slices++;
      if (m_eof === 1'b1) eof_at = dut_slices;
    end
    chk("m_valid", m_valid, ev);
    if (ev) begin
      chk("m_c0", m_c0, e0);
      chk("m_c1", m_c1, e1);
      chk("sol_eol_eof", {m_sol, m_eol, m_eof}, ef);
    end
  endtask

  // pat 0: pixel = row*16+col; pat 1: random. gap 0: none, 1: every other, 2: random.
  task automatic send_frame(input int pat, input int gap, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      int r;
      int c;
      logic [15:0] d;
      r = i / HW;
      c = i % HW;
      if (pat == 0) d = {8'(r*16 + 2*c + 1), 8'(r*16 + 2*c)};
      else d = 16'($urandom);
      if (gap == 1 && i > 0) beat(1'b0, 1'b0, 1'b0, 16'($urandom));
      else if (gap == 2 && $urandom_range(0, 2) == 0) beat(1'b0, 1'b1, 1'b0, 16'($urandom));
      beat(1'b1, i == 0, c == HW-1, d);
      if (pat == 0 && i == 3*HW) begin
        chk("golden_c0", m_c0, 32'h30201000);
        chk("golden_c1", m_c1, 32'h31211101);
        chk("golden_sol", m_sol, 1'b1);
      end
    end
  endtask

  initial begin
`ifdef FEEDER_FRAME_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    #12;
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_c0", m_c0, 32'h0);
    chk("rst_c1", m_c1, 32'h0);
    chk("rst_flags", {m_sol, m_eol, m_eof}, 3'b000);
    chk("rst_err", frame_err, 1'b0);
    chk("rst_ready", s_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready", s_ready, 1'b1);
    @(posedge clk);
    #1;

    // Beats before any start of frame are dropped.
    for (int i = 0; i < 4; i++) beat(1'b1, 1'b0, 1'b0, 16'($urandom));

    // Patterned frame, no gaps.
    dut_slices = 0; eof_at = 0;
    send_frame(0, 0, NB);
    chk("slices_golden", dut_slices, 12);
    chk("eof_golden", eof_at, 12);
    chk("err_clean", frame_err, 1'b0);

    // Same frame with a gap every other cycle.
    dut_slices = 0; eof_at = 0;
    send_frame(0, 1, NB);
    beat(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("slices_gap", dut_slices, 12);
    chk("eof_gap", eof_at, 12);

    // Random pixels with random gaps.
    dut_slices = 0; eof_at = 0;
    send_frame(1, 2, NB);
    chk("slices_rand", dut_slices, 12);
    chk("eof_rand", eof_at, 12);

    // Restart at row 4, col 2.
    send_frame(1, 0, 4*HW + 2);
    dut_slices = 0; eof_at = 0;
    send_frame(1, 2, NB);
    chk("slices_restart", dut_slices, 12);
    chk("eof_restart", eof_at, 12);

    // Reset in the middle of the row-5 pass.
    send_frame(1, 0, 5*HW + 2);
    s_valid = 1'b0;
    #1;
    rst = 1'b1;
    act = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid, 1'b0);
    chk("mid_rst_c0", m_c0, 32'h0);
    chk("mid_rst_c1", m_c1, 32'h0);
    chk("mid_rst_flags", {m_sol, m_eol, m_eof}, 3'b000);
    chk("mid_rst_ready", s_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dut_slices = 0; eof_at = 0;
    send_frame(0, 0, NB);
    chk("slices_after_rst", dut_slices, 12);
    chk("eof_after_rst", eof_at, 12);

    // Early end-of-line at row 1, col 2.
    beat(1'b1, 1'b1, 1'b0, 16'($urandom));
    for (int i = 1; i < HW; i++) beat(1'b1, 1'b0, i == HW-1, 16'($urandom));
    beat(1'b1, 1'b0, 1'b0, 16'($urandom));
    beat(1'b1, 1'b0, 1'b0, 16'($urandom));
    beat(1'b1, 1'b0, 1'b1, 16'($urandom));
    chk("err_set", frame_err, exp_err);
    beat(1'b1, 1'b0, 1'b0, 16'($urandom));
    beat(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("err_sticky", frame_err, exp_err);
    send_frame(1, 0, 1);
    chk("err_cleared", frame_err, 1'b0);
    dut_slices = 0; eof_at = 0;
    send_frame(1, 0, NB);
    chk("slices_final", dut_slices, 12);
    chk("err_final", frame_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
